sprite_raster_datapath: RTL and testbench

//  Per-object datapath for the game's moving sprites (car, pedestrian). Holds the

---
 rtl/sprite_raster_datapath.sv | 164 ++++++++++++++++
 tb/tb_sprite_raster_datapath.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_raster_datapath.sv
`default_nettype none
// ============================================================================
// sprite_raster_datapath: sprite position register plus WIDTH x HEIGHT raster.
// Revision 1.0 - initial release
// ============================================================================
module sprite_raster_datapath #(
  parameter int WIDTH   = 27,
  parameter int HEIGHT  = 48,
  parameter int ADDR_W  = 11,
  parameter int X_INIT  = 0,
  parameter int Y_INIT  = 0,
  parameter int STEP    = 4,
  parameter int AUTO_DY = 0,
  parameter int WRAP_Y  = 0,
  parameter int X_MAX   = 319,
  parameter int Y_MAX   = 239
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              enable,
  input  logic              move,
  input  logic              left,
  input  logic              right,
  input  logic              up,
  input  logic              down,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [2:0]        rom_data,
  output logic [8:0]        pos_x,
  output logic [7:0]        pos_y,
  output logic [8:0]        x_final,
  output logic [7:0]        y_final,
  output logic [2:0]        colour,
  output logic              done
);

  localparam int CX_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int CY_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  localparam logic [CX_W-1:0] CX_LAST = CX_W'(WIDTH - 1);
  localparam logic [CY_W-1:0] CY_LAST = CY_W'(HEIGHT - 1);

  localparam logic signed [10:0] STEP_S = 11'(STEP);
  localparam logic signed [10:0] AUTO_S = 11'(AUTO_DY);
  localparam logic signed [10:0] X_LIM  = 11'(X_MAX - WIDTH + 1);
  localparam logic signed [10:0] Y_LIM  = 11'(Y_MAX - HEIGHT + 1);

  logic [1:0]        state;
  logic [CX_W-1:0]   cx;
  logic [CY_W-1:0]   cy;
  logic [ADDR_W-1:0] addr;
  logic              pix_valid;
  logic [2:0]        colour_q;
  logic              scan_go;
  logic              last_pix;

  logic signed [10:0] dx, dy, nx, ny;
  logic [8:0]         new_x;
  logic [7:0]         new_y;

  assign scan_go  = (state == S_SCAN) && enable;
  assign last_pix = (cx == CX_LAST) && (cy == CY_LAST);
  assign rom_addr = addr;
  assign done     = (state == S_FLUSH) && enable;
  // ROM data arrives alongside the registered pixel coordinates; hold it after.
  assign colour   = pix_valid ? rom_data : colour_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      cx    <= '0;
      cy    <= '0;
      addr  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cx   <= '0;
          cy   <= '0;
          addr <= '0;
          if (enable) state <= S_SCAN;
        end
        S_SCAN: begin
          if (!enable || last_pix) begin
            state <= enable ? S_FLUSH : S_IDLE;
            cx    <= '0;
            cy    <= '0;
            addr  <= '0;
          end else begin
            addr <= addr + 1'b1;
            if (cx == CX_LAST) begin
              cx <= '0;
              cy <= cy + 1'b1;
            end else begin
              cx <= cx + 1'b1;
            end
          end
        end
        S_FLUSH: begin
          cx    <= '0;
          cy    <= '0;
          addr  <= '0;
          state <= enable ? S_HOLD : S_IDLE;
        end
        S_HOLD: begin
          cx   <= '0;
          cy   <= '0;
          addr <= '0;
          if (!enable) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pix_valid <= 1'b0;
      x_final   <= '0;
      y_final   <= '0;
      colour_q  <= '0;
    end else begin
      pix_valid <= scan_go;
      if (scan_go) begin
        x_final <= pos_x + 9'(cx);
        y_final <= pos_y + 8'(cy);
      end
      if (pix_valid) colour_q <= rom_data;
    end
  end

  always_comb begin
    dx = '0;
    dy = AUTO_S;
    if (right && !left)      dx = STEP_S;
    else if (left && !right) dx = -STEP_S;
    if (down && !up)         dy = AUTO_S + STEP_S;
    else if (up && !down)    dy = AUTO_S - STEP_S;
    nx = $signed({2'b00, pos_x}) + dx;
    ny = $signed({3'b000, pos_y}) + dy;
    if (nx < 0)          new_x = '0;
    else if (nx > X_LIM) new_x = 9'(X_LIM);
    else                 new_x = 9'(nx);
    // Past the bottom limit the sprite either re-enters at the top or sticks.
    if (ny < 0)          new_y = '0;
    else if (ny > Y_LIM) new_y = (WRAP_Y != 0) ? 8'd0 : 8'(Y_LIM);
    else                 new_y = 8'(ny);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pos_x <= 9'(X_INIT);
      pos_y <= 8'(Y_INIT);
    end else if (move) begin
      pos_x <= new_x;
      pos_y <= new_y;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sprite_raster_datapath.sv
`default_nettype none
// Bench for sprite_raster_datapath: a small 3x2 sprite for raster checks and a
// 27x48 wrapping sprite for vertical wrap, both checked against a reference model.
module tb_sprite_raster_datapath;

  logic       clock = 1'b0;
  logic       resetn, enable, move, left, right, up, down;
  logic [2:0] rom_addr;
  logic [2:0] rom_data;
  logic [8:0] pos_x, x_final;
  logic [7:0] pos_y, y_final;
  logic [2:0] colour;
  logic       done;

  logic        enable_b, move_b;
  logic [10:0] rom_addr_b;
  logic [2:0]  rom_data_b;
  logic [8:0]  pos_x_b, x_final_b;
  logic [7:0]  pos_y_b, y_final_b;
  logic [2:0]  colour_b;
  logic        done_b;

  int vectors;
  int miscompares;
  int mx, my, mbx, mby;

  typedef struct {
    bit l, r, u, d;
    int ex, ey;
  } mv_t;
  mv_t tbl[10];

  always #5 clock = ~clock;

  sprite_raster_datapath #(
    .WIDTH(3), .HEIGHT(2), .ADDR_W(3), .X_INIT(10), .Y_INIT(20),
    .STEP(4), .AUTO_DY(0), .WRAP_Y(0), .X_MAX(319), .Y_MAX(239)
  ) dut (
    .clock(clock), .resetn(resetn), .enable(enable), .move(move),
    .left(left), .right(right), .up(up), .down(down),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .pos_x(pos_x), .pos_y(pos_y), .x_final(x_final), .y_final(y_final),
    .colour(colour), .done(done)
  );

  sprite_raster_datapath #(
    .WIDTH(27), .HEIGHT(48), .ADDR_W(11), .X_INIT(0), .Y_INIT(188),
    .STEP(4), .AUTO_DY(4), .WRAP_Y(1), .X_MAX(319), .Y_MAX(239)
  ) dut_b (
    .clock(clock), .resetn(resetn), .enable(enable_b), .move(move_b),
    .left(left), .right(right), .up(up), .down(down),
    .rom_addr(rom_addr_b), .rom_data(rom_data_b),
    .pos_x(pos_x_b), .pos_y(pos_y_b), .x_final(x_final_b), .y_final(y_final_b),
    .colour(colour_b), .done(done_b)
  );

  // Synchronous ROM: data for an address appears one clock later.
  always @(posedge clock) rom_data <= 3'((int'(rom_addr) * 5 + 3) % 8);
  assign rom_data_b = 3'd0;

  function automatic int mv_x(int x, bit l, bit r, int lim);
    int n;
    n = x + 4 * (int'(r) - int'(l));
    if (n < 0) n = 0;
    if (n > lim) n = lim;
    return n;
  endfunction

  function automatic int mv_y(int y, bit u, bit d, int adj, bit wrap, int lim);
    int n;
    n = y + 4 * (int'(d) - int'(u)) + adj;
    if (n < 0) return 0;
    if (n > lim) return wrap ? 0 : lim;
    return n;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_move(input bit ma, input bit mb, input bit l, input bit r,
                         input bit u, input bit d);
    left = l; right = r; up = u; down = d;
    move = ma; move_b = mb;
    @(posedge clock); #1;
    move = 0; move_b = 0; left = 0; right = 0; up = 0; down = 0;
    if (ma) begin
      mx = mv_x(mx, l, r, 317);
      my = mv_y(my, u, d, 0, 1'b0, 238);
      chk("pos_x", pos_x, mx);
      chk("pos_y", pos_y, my);
    end
    if (mb) begin
      mbx = mv_x(mbx, l, r, 293);
      mby = mv_y(mby, u, d, 4, 1'b1, 192);
      chk("pos_x_b", pos_x_b, mbx);
      chk("pos_y_b", pos_y_b, mby);
    end
  endtask

  // One raster of the 3x2 sprite; optional move (right) or abort before pixel k.
  task automatic scan(input int move_at, input int abort_at);
    int bx, by;
    bit stop;
    stop = 0;
    enable = 1;
    @(posedge clock); #1;
    chk("scan_entry_addr", rom_addr, 0);
    chk("scan_entry_done", done, 0);
    for (int k = 0; k < 6 && !stop; k++) begin
      bx = mx; by = my;
      if (k == abort_at) enable = 0;
      if (k == move_at) begin move = 1; right = 1; end
      @(posedge clock); #1;
      if (k == move_at) begin
        move = 0; right = 0;
        mx = mv_x(mx, 1'b0, 1'b1, 317);
        chk("scan_move_pos_x", pos_x, mx);
      end
      if (k == abort_at) begin
        chk("abort_done", done, 0);
        chk("abort_addr", rom_addr, 0);
        chk("abort_hold_x", x_final, bx + (k - 1) % 3);
        stop = 1;
      end else begin
        chk("pix_x", x_final, bx + k % 3);
        chk("pix_y", y_final, by + k / 3);
        chk("pix_colour", colour, (k * 5 + 3) % 8);
        chk("pix_done", done, (k == 5) ? 1 : 0);
        if (k < 5) chk("pix_addr", rom_addr, k + 1);
      end
    end
  endtask

  task automatic end_scan();
    enable = 0;
    @(posedge clock); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vectors = 0; miscompares = 0;
    tbl[0] = '{0, 1, 0, 0, 14, 20};
    tbl[1] = '{0, 0, 0, 1, 14, 24};
    tbl[2] = '{1, 1, 0, 0, 14, 24};
    tbl[3] = '{0, 0, 1, 1, 14, 24};
    tbl[4] = '{1, 0, 0, 0, 10, 24};
    tbl[5] = '{1, 0, 1, 0,  6, 20};
    tbl[6] = '{1, 0, 0, 0,  2, 20};
    tbl[7] = '{1, 0, 0, 0,  0, 20};
    tbl[8] = '{0, 0, 1, 0,  0, 16};
    tbl[9] = '{0, 1, 0, 1,  4, 20};

    resetn = 0; enable = 0; move = 0; left = 0; right = 0; up = 0; down = 0;
    enable_b = 0; move_b = 0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_pos_x", pos_x, 10);
    chk("rst_pos_y", pos_y, 20);
    chk("rst_x_final", x_final, 0);
    chk("rst_y_final", y_final, 0);
    chk("rst_colour", colour, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", rom_addr, 0);
    chk("rst_pos_y_b", pos_y_b, 188);
    resetn = 1;
    mx = 10; my = 20; mbx = 0; mby = 188;

    scan(-1, -1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      chk("hold_done", done, 0);
      chk("hold_x", x_final, 12);
      chk("hold_y", y_final, 21);
    end
    end_scan();
    scan(-1, -1);
    end_scan();

    scan(-1, 3);
    repeat (2) begin
      @(posedge clock); #1;
      chk("idle_done", done, 0);
      chk("idle_addr", rom_addr, 0);
    end
    scan(-1, -1);
    end_scan();

    scan(2, -1);
    end_scan();

    // Asynchronous reset in the middle of a raster.
    enable = 1;
    repeat (3) @(posedge clock);
    #3;
    resetn = 0;
    #1;
    chk("amid_pos_x", pos_x, 10);
    chk("amid_pos_y", pos_y, 20);
    chk("amid_x_final", x_final, 0);
    chk("amid_y_final", y_final, 0);
    chk("amid_colour", colour, 0);
    chk("amid_done", done, 0);
    chk("amid_addr", rom_addr, 0);
    enable = 0;
    @(posedge clock); #1;
    resetn = 1;
    mx = 10; my = 20; mbx = 0; mby = 188;
    repeat (4) begin
      @(posedge clock); #1;
      chk("post_rst_x", x_final, 0);
      chk("post_rst_done", done, 0);
    end

    for (int i = 0; i < 10; i++) begin
      do_move(1, 0, tbl[i].l, tbl[i].r, tbl[i].u, tbl[i].d);
      chk("tbl_x", pos_x, tbl[i].ex);
      chk("tbl_y", pos_y, tbl[i].ey);
    end

    do_move(0, 1, 0, 0, 0, 0);
    chk("wrap_y_192", pos_y_b, 192);
    do_move(0, 1, 0, 0, 0, 0);
    chk("wrap_y_0", pos_y_b, 0);
    do_move(0, 1, 0, 0, 0, 0);
    chk("wrap_y_4", pos_y_b, 4);

    repeat (80) do_move(1, 0, 0, 1, 0, 0);
    repeat (60) do_move(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 150; i++) begin
      do_move(1, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    scan(-1, -1);
    end_scan();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
